step_ramp_sequencer: RTL

// Trapezoidal step-pulse sequencer for one stepper axis. Owns a programmable period

---
 rtl/step_ramp_sequencer.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/step_ramp_sequencer.sv
// Trapezoidal step/dir pulse sequencer for a single stepper axis.
// It ramps the step period from P_max down to P_min, cruises, then ramps back to P_max.
module step_ramp_sequencer #(
  parameter int SIZE      = 8,
  parameter int COUNT_W   = 16,
  parameter int DIR_SETUP = 4
) (
  input  logic               clk_in,
  input  logic               rst_in,
  input  logic               start_in,
  input  logic               stop_in,
  input  logic               dir_in,
  input  logic [COUNT_W-1:0] steps_in,
  input  logic [SIZE-1:0]    period_max_in,
  input  logic [SIZE-1:0]    period_min_in,
  input  logic [SIZE-1:0]    accel_in,
  output logic               step_out,
  output logic               dir_out,
  output logic               busy_out,
  output logic               done_out,
  output logic [SIZE-1:0]    period_out,
  output logic [COUNT_W-1:0] remaining_out
);

  typedef enum logic [1:0] {IDLE, SETTLE, RUN, DONE} state_t;

  localparam int SET_W = (DIR_SETUP > 1) ? $clog2(DIR_SETUP) : 1;
  localparam logic [SET_W-1:0] SETTLE_LAST = SET_W'(DIR_SETUP - 1);

  state_t             state;
  state_t             state_nxt;
  logic [SET_W-1:0]   settle_cnt;
  logic [SIZE-1:0]    tick;
  logic [COUNT_W-1:0] ramp;
  logic [SIZE-1:0]    pmin_q;
  logic [SIZE-1:0]    pmax_q;
  logic [SIZE-1:0]    accel_q;

  logic [SIZE-1:0]    pmin_san;
  logic [SIZE-1:0]    pmax_san;
  logic               start_ok;
  logic               terminal;
  logic [COUNT_W-1:0] r_next;
  logic [SIZE:0]      sum;
  logic [SIZE:0]      diff;
  logic [SIZE-1:0]    per_up;
  logic [SIZE-1:0]    per_dn;

  // A zero P_min would stall the divider; P_max below P_min collapses to constant speed.
  always_comb begin
    pmin_san = (period_min_in == '0) ? SIZE'(1) : period_min_in;
    pmax_san = (period_max_in < pmin_san) ? pmin_san : period_max_in;
    start_ok = start_in && !stop_in;
    terminal = (tick == period_out - SIZE'(1));
    r_next   = remaining_out - COUNT_W'(1);
    sum      = {1'b0, period_out} + {1'b0, accel_q};
    diff     = {1'b0, period_out} - {1'b0, accel_q};
    per_up   = (sum > {1'b0, pmax_q}) ? pmax_q : sum[SIZE-1:0];
    per_dn   = (diff[SIZE] || (diff[SIZE-1:0] < pmin_q)) ? pmin_q : diff[SIZE-1:0];
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // RUN leaves one cycle after the final pulse, so done_out trails the last step.
  always_comb begin
    state_nxt = state;
    busy_out  = 1'b0;
    done_out  = 1'b0;
    unique case (state)
      IDLE: begin
        if (start_ok) state_nxt = (steps_in == '0) ? DONE : SETTLE;
      end
      SETTLE: begin
        busy_out = 1'b1;
        if (stop_in) state_nxt = DONE;
        else if (settle_cnt == SETTLE_LAST) state_nxt = RUN;
      end
      RUN: begin
        busy_out = 1'b1;
        if (stop_in || (remaining_out == '0)) state_nxt = DONE;
      end
      DONE: begin
        done_out  = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      step_out      <= 1'b0;
      dir_out       <= 1'b0;
      period_out    <= '0;
      remaining_out <= '0;
      settle_cnt    <= '0;
      tick          <= '0;
      ramp          <= '0;
      pmin_q        <= '0;
      pmax_q        <= '0;
      accel_q       <= '0;
    end else begin
      step_out <= 1'b0;
      case (state)
        IDLE: begin
          if (start_ok) begin
            dir_out       <= dir_in;
            remaining_out <= steps_in;
            pmin_q        <= pmin_san;
            pmax_q        <= pmax_san;
            accel_q       <= accel_in;
            period_out    <= pmax_san;
            ramp          <= '0;
            tick          <= '0;
            settle_cnt    <= '0;
          end
        end
        SETTLE: settle_cnt <= settle_cnt + SET_W'(1);
        RUN: begin
          // Stepping is gated on staying in RUN so a stop beats a same-cycle terminal tick.
          if (state_nxt == RUN) begin
            if (terminal) begin
              step_out      <= 1'b1;
              remaining_out <= r_next;
              tick          <= '0;
              if (r_next != '0) begin
                if ((r_next <= ramp) && (ramp != '0)) begin
                  period_out <= per_up;
                  ramp       <= ramp - COUNT_W'(1);
                end else if (period_out > pmin_q) begin
                  period_out <= per_dn;
                  ramp       <= ramp + COUNT_W'(1);
                end
              end
            end else begin
              tick <= tick + SIZE'(1);
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule
